// File: rtl/mem_access_ctrl.sv
// LC-3 memory access sequencer: drives async SRAM strobes for a fixed number of
// wait cycles, captures read data, and decodes a single memory-mapped I/O word.
module mem_access_ctrl #(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic        Wr,
    input  logic [15:0] Addr,
    input  logic [15:0] WData,
    output logic [15:0] RData,
    output logic        Done,
    output logic        Busy,
    input  logic [15:0] Switches,
    output logic [15:0] HexOut,
    output logic [19:0] SRAM_ADDR,
    output logic [15:0] Data_to_SRAM,
    input  logic [15:0] Data_from_SRAM,
    output logic        SRAM_DQ_OE,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] IO     = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic [15:0] hex_q, hex_d;
    logic        in_access;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        hex_d   = hex_q;
        case (state_q)
            IDLE: begin
                if (Req) begin
                    wr_d    = Wr;
                    addr_d  = Addr;
                    wdata_d = WData;
                    if (Addr == IO_ADDR) begin
                        state_d = IO;
                    end else begin
                        state_d = ACCESS;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            ACCESS: begin
                // counter==0 marks the final cycle: read sample point / write data-hold
                if (cnt_q == 4'd0) begin
                    if (!wr_q) begin
                        rdata_d = Data_from_SRAM;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            IO: begin
                if (wr_q) begin
                    hex_d = wdata_q;
                end else begin
                    rdata_d = Switches;
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            addr_q  <= 16'd0;
            wdata_q <= 16'd0;
            rdata_q <= 16'd0;
            hex_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            hex_q   <= hex_d;
        end
    end

    // Strobes decode only from registers, so they cannot glitch on Req/Addr.
    assign in_access    = (state_q == ACCESS);
    assign Done         = (state_q == DONE);
    assign Busy         = (state_q != IDLE);
    assign SRAM_CE_N    = ~in_access;
    assign SRAM_UB_N    = ~in_access;
    assign SRAM_LB_N    = ~in_access;
    assign SRAM_OE_N    = ~(in_access & ~wr_q);
    assign SRAM_WE_N    = ~(in_access & wr_q & (cnt_q != 4'd0));
    assign SRAM_DQ_OE   = in_access & wr_q;
    assign SRAM_ADDR    = {4'b0000, addr_q};
    assign Data_to_SRAM = wdata_q;
    assign RData        = rdata_q;
    assign HexOut       = hex_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: WAIT_CYCLES=2 instance plus a WAIT_CYCLES=1 instance.
`timescale 1ns/1ps
module tb_mem_access_ctrl;

    localparam int WC = 2;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        Reset, Req, Wr;
    logic [15:0] Addr, WData, Switches, Data_from_SRAM;
    logic [15:0] RData, HexOut, Data_to_SRAM;
    logic [19:0] SRAM_ADDR;
    logic        Done, Busy, SRAM_DQ_OE, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;

    logic        b_Req, b_Wr;
    logic [15:0] b_Addr, b_WData, b_Switches, b_Data_from_SRAM;
    logic [15:0] b_RData, b_HexOut, b_Data_to_SRAM;
    logic [19:0] b_SRAM_ADDR;
    logic        b_Done, b_Busy, b_DQ_OE, b_CE_N, b_OE_N, b_WE_N, b_UB_N, b_LB_N;

    mem_access_ctrl #(.WAIT_CYCLES(WC), .IO_ADDR(16'hFFFF)) u_dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .Wr(Wr), .Addr(Addr), .WData(WData),
        .RData(RData), .Done(Done), .Busy(Busy), .Switches(Switches), .HexOut(HexOut),
        .SRAM_ADDR(SRAM_ADDR), .Data_to_SRAM(Data_to_SRAM), .Data_from_SRAM(Data_from_SRAM),
        .SRAM_DQ_OE(SRAM_DQ_OE), .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N),
        .SRAM_WE_N(SRAM_WE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N)
    );

    mem_access_ctrl #(.WAIT_CYCLES(1), .IO_ADDR(16'hFFFF)) u_dut1 (
        .Clk(Clk), .Reset(Reset), .Req(b_Req), .Wr(b_Wr), .Addr(b_Addr), .WData(b_WData),
        .RData(b_RData), .Done(b_Done), .Busy(b_Busy), .Switches(b_Switches), .HexOut(b_HexOut),
        .SRAM_ADDR(b_SRAM_ADDR), .Data_to_SRAM(b_Data_to_SRAM), .Data_from_SRAM(b_Data_from_SRAM),
        .SRAM_DQ_OE(b_DQ_OE), .SRAM_CE_N(b_CE_N), .SRAM_OE_N(b_OE_N),
        .SRAM_WE_N(b_WE_N), .SRAM_UB_N(b_UB_N), .SRAM_LB_N(b_LB_N)
    );

    int          checks = 0;
    int          errors = 0;
    logic [15:0] rd_q[$];
    logic [15:0] hex_q[$];
    logic [15:0] model_rdata = 16'h0000;
    logic [15:0] expv;

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    // Drives Req in cycle 0 and returns one step into cycle 1 with Req dropped.
    task automatic issue(input logic wr, input logic [15:0] a, input logic [15:0] wd);
        next_cycle();
        Req = 1'b1; Wr = wr; Addr = a; WData = wd;
        next_cycle();
        Req = 1'b0;
    endtask

    // Leaves the caller at the falling edge of the Done cycle; n = -1 when Done never rises.
    task automatic wait_done(input int start, output int n);
        bit seen;
        seen = 1'b0;
        n = start;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge Clk);
            if (Done === 1'b1) seen = 1'b1;
            else begin
                next_cycle();
                n++;
            end
        end
        if (!seen) n = -1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge Clk);
        checks++;
        if ({RData, HexOut, Data_to_SRAM} !== 48'h0) begin
            errors++;
            $display("FAIL reset_data: RData=%h HexOut=%h DtoS=%h required all 0", RData, HexOut, Data_to_SRAM);
        end
        checks++;
        if (SRAM_ADDR !== 20'h0) begin
            errors++;
            $display("FAIL reset_addr: got %h required 0", SRAM_ADDR);
        end
        checks++;
        if ({Done, Busy, SRAM_DQ_OE} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: Done/Busy/DQ_OE=%b required 000", {Done, Busy, SRAM_DQ_OE});
        end
        checks++;
        if ({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N} !== 5'b11111) begin
            errors++;
            $display("FAIL reset_strobes: got %b required 11111",
                     {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N});
        end
        next_cycle();
        Reset = 1'b0;
    endtask

    task automatic test_read();
        rd_q.delete();
        Data_from_SRAM = 16'hBEEF;
        issue(1'b0, 16'h0040, 16'h0000);
        rd_q.push_back(16'hBEEF);
        for (int c = 1; c <= WC + 1; c++) begin
            @(negedge Clk);
            checks++;
            if ({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_DQ_OE, Done} !== 7'b0010000) begin
                errors++;
                $display("FAIL read_strobes c%0d: CE,OE,WE,UB,LB,DQ_OE,Done=%b required 0010000", c,
                         {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_DQ_OE, Done});
            end
            checks++;
            if (SRAM_ADDR !== 20'h00040) begin
                errors++;
                $display("FAIL read_addr c%0d: got %h required 00040", c, SRAM_ADDR);
            end
            next_cycle();
        end
        @(negedge Clk);
        checks++;
        if (Done !== 1'b1) begin
            errors++;
            $display("FAIL read_done c%0d: Done=%b required 1", WC + 2, Done);
        end else begin
            expv = rd_q.pop_front();
            checks++;
            if (RData !== expv) begin
                errors++;
                $display("FAIL read_rdata: got %h required %h", RData, expv);
            end
        end
        model_rdata = 16'hBEEF;
        next_cycle();
        @(negedge Clk);
        checks++;
        if ({Busy, Done} !== 2'b00) begin
            errors++;
            $display("FAIL read_idle c%0d: Busy,Done=%b required 00", WC + 3, {Busy, Done});
        end
    endtask

    task automatic test_write();
        rd_q.delete();
        issue(1'b1, 16'h0100, 16'h1234);
        rd_q.push_back(model_rdata);
        for (int c = 1; c <= WC + 1; c++) begin
            @(negedge Clk);
            checks++;
            if ({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_DQ_OE, Done} !== {1'b0, 1'b1, (c == WC + 1), 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL write_strobes c%0d: CE,OE,WE,DQ_OE,Done=%b required %b", c,
                         {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_DQ_OE, Done},
                         {1'b0, 1'b1, (c == WC + 1), 1'b1, 1'b0});
            end
            checks++;
            if ({SRAM_ADDR, Data_to_SRAM} !== {20'h00100, 16'h1234}) begin
                errors++;
                $display("FAIL write_bus c%0d: addr=%h data=%h required 00100/1234", c, SRAM_ADDR, Data_to_SRAM);
            end
            next_cycle();
        end
        @(negedge Clk);
        checks++;
        if (Done !== 1'b1) begin
            errors++;
            $display("FAIL write_done: Done=%b required 1", Done);
        end else begin
            expv = rd_q.pop_front();
            checks++;
            if (RData !== expv) begin
                errors++;
                $display("FAIL write_rdata_held: got %h required %h", RData, expv);
            end
        end
        next_cycle();
    endtask

    task automatic test_io();
        rd_q.delete();
        hex_q.delete();
        Switches = 16'h00A5;
        issue(1'b0, 16'hFFFF, 16'h0000);
        rd_q.push_back(16'h00A5);
        @(negedge Clk);
        checks++;
        if ({SRAM_CE_N, SRAM_OE_N, Busy, Done} !== 4'b1110) begin
            errors++;
            $display("FAIL io_rd_c1: CE,OE,Busy,Done=%b required 1110", {SRAM_CE_N, SRAM_OE_N, Busy, Done});
        end
        next_cycle();
        @(negedge Clk);
        checks++;
        if (Done !== 1'b1 || SRAM_CE_N !== 1'b1) begin
            errors++;
            $display("FAIL io_rd_done: Done,CE=%b required 11", {Done, SRAM_CE_N});
        end else begin
            expv = rd_q.pop_front();
            checks++;
            if (RData !== expv) begin
                errors++;
                $display("FAIL io_rd_rdata: got %h required %h", RData, expv);
            end
        end
        model_rdata = 16'h00A5;
        Switches = 16'h0000;
        next_cycle();
        issue(1'b1, 16'hFFFF, 16'h0F0F);
        hex_q.push_back(16'h0F0F);
        @(negedge Clk);
        checks++;
        if ({SRAM_CE_N, SRAM_WE_N, SRAM_DQ_OE, Done} !== 4'b1100) begin
            errors++;
            $display("FAIL io_wr_c1: CE,WE,DQ_OE,Done=%b required 1100", {SRAM_CE_N, SRAM_WE_N, SRAM_DQ_OE, Done});
        end
        next_cycle();
        @(negedge Clk);
        checks++;
        if (Done !== 1'b1 || SRAM_CE_N !== 1'b1) begin
            errors++;
            $display("FAIL io_wr_done: Done,CE=%b required 11", {Done, SRAM_CE_N});
        end else begin
            expv = hex_q.pop_front();
            checks++;
            if ({HexOut, RData} !== {expv, model_rdata}) begin
                errors++;
                $display("FAIL io_wr_hex: HexOut=%h RData=%h required %h/%h", HexOut, RData, expv, model_rdata);
            end
        end
        next_cycle();
    endtask

    task automatic test_req_busy();
        int dn;
        int n;
        dn = 0;
        rd_q.delete();
        Data_from_SRAM = 16'h5A5A;
        issue(1'b0, 16'h0200, 16'h0000);
        rd_q.push_back(16'h5A5A);
        for (int c = 1; c <= 5; c++) begin
            Req = 1'b1; Wr = 1'b0; Addr = 16'h0300;
            if (c == 4) Data_from_SRAM = 16'h1111;
            if (c == 5) rd_q.push_back(16'h1111);
            @(negedge Clk);
            if (c <= 4) begin
                checks++;
                if (SRAM_ADDR !== 20'h00200) begin
                    errors++;
                    $display("FAIL busy_addr c%0d: got %h required 00200", c, SRAM_ADDR);
                end
            end
            if (Done === 1'b1) begin
                dn++;
                expv = rd_q.pop_front();
                checks++;
                if (RData !== expv) begin
                    errors++;
                    $display("FAIL busy_rdata c%0d: got %h required %h", c, RData, expv);
                end
            end
            next_cycle();
        end
        Req = 1'b0;
        checks++;
        if (dn !== 1) begin
            errors++;
            $display("FAIL busy_done_count: got %0d required 1", dn);
        end
        @(negedge Clk);
        checks++;
        if ({Busy, SRAM_ADDR} !== {1'b1, 20'h00300}) begin
            errors++;
            $display("FAIL busy_new_access: Busy=%b addr=%h required 1/00300", Busy, SRAM_ADDR);
        end
        next_cycle();
        wait_done(7, n);
        checks++;
        if (n != 5 + WC + 2) begin
            errors++;
            $display("FAIL busy_second_latency: done cycle %0d required %0d", n, 5 + WC + 2);
        end else begin
            expv = rd_q.pop_front();
            checks++;
            if (RData !== expv) begin
                errors++;
                $display("FAIL busy_second_rdata: got %h required %h", RData, expv);
            end
        end
        model_rdata = 16'h1111;
        next_cycle();
    endtask

    task automatic test_reset_mid_write();
        int dn;
        int n;
        rd_q.delete();
        issue(1'b1, 16'h0400, 16'hCAFE);
        next_cycle();
        #2;
        checks++;
        if ({SRAM_WE_N, SRAM_DQ_OE} !== 2'b01) begin
            errors++;
            $display("FAIL rstw_pre: WE,DQ_OE=%b required 01", {SRAM_WE_N, SRAM_DQ_OE});
        end
        Reset = 1'b1;
        #1;
        checks++;
        if ({SRAM_WE_N, SRAM_DQ_OE, SRAM_CE_N, Busy} !== 4'b1010) begin
            errors++;
            $display("FAIL rstw_async: WE,DQ_OE,CE,Busy=%b required 1010",
                     {SRAM_WE_N, SRAM_DQ_OE, SRAM_CE_N, Busy});
        end
        checks++;
        if ({RData, HexOut} !== 32'h0) begin
            errors++;
            $display("FAIL rstw_clear: RData=%h HexOut=%h required 0/0", RData, HexOut);
        end
        model_rdata = 16'h0000;
        next_cycle();
        next_cycle();
        Reset = 1'b0;
        dn = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge Clk);
            if (Done === 1'b1 || Busy === 1'b1) dn++;
            next_cycle();
        end
        checks++;
        if (dn != 0) begin
            errors++;
            $display("FAIL rstw_no_done: %0d active cycles after reset required 0", dn);
        end
        Data_from_SRAM = 16'h7777;
        issue(1'b0, 16'h0050, 16'h0000);
        rd_q.push_back(16'h7777);
        wait_done(1, n);
        checks++;
        if (n != WC + 2) begin
            errors++;
            $display("FAIL rstw_read_latency: done cycle %0d required %0d", n, WC + 2);
        end else begin
            expv = rd_q.pop_front();
            checks++;
            if (RData !== expv) begin
                errors++;
                $display("FAIL rstw_read_rdata: got %h required %h", RData, expv);
            end
        end
        model_rdata = 16'h7777;
        next_cycle();
    endtask

    task automatic test_back_to_back();
        int dn;
        rd_q.delete();
        dn = 0;
        Data_from_SRAM = 16'h2222;
        issue(1'b0, 16'h0060, 16'h0000);
        rd_q.push_back(16'h2222);
        Req = 1'b1;
        for (int c = 1; c <= 3 * (WC + 3) - 1; c++) begin
            if (c == 2 * (WC + 3) + 1) Req = 1'b0;
            @(negedge Clk);
            if (Done === 1'b1) begin
                dn++;
                checks++;
                if (c != dn * (WC + 3) - 1) begin
                    errors++;
                    $display("FAIL b2b_spacing: done #%0d in cycle %0d required %0d", dn, c, dn * (WC + 3) - 1);
                end
                if (rd_q.size() > 0) begin
                    expv = rd_q.pop_front();
                    checks++;
                    if (RData !== expv) begin
                        errors++;
                        $display("FAIL b2b_rdata: got %h required %h", RData, expv);
                    end
                end
                if (Req) rd_q.push_back(16'h2222);
            end
            next_cycle();
        end
        Req = 1'b0;
        checks++;
        if (dn != 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d Done pulses required 3", dn);
        end
        @(negedge Clk);
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: Busy=%b required 0", Busy);
        end
        next_cycle();
    endtask

    task automatic test_wait1();
        int  n;
        int  wl;
        bit  seen;
        b_Data_from_SRAM = 16'h3C3C;
        next_cycle();
        b_Req = 1'b1; b_Wr = 1'b0; b_Addr = 16'h0010;
        next_cycle();
        b_Req = 1'b0;
        n = -1; seen = 1'b0;
        for (int c = 1; c <= 8 && !seen; c++) begin
            @(negedge Clk);
            if (b_Done === 1'b1) begin seen = 1'b1; n = c; end
            else next_cycle();
        end
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL w1_read_latency: done cycle %0d required 3", n);
        end
        checks++;
        if (b_RData !== 16'h3C3C) begin
            errors++;
            $display("FAIL w1_read_rdata: got %h required 3c3c", b_RData);
        end
        next_cycle();
        b_Req = 1'b1; b_Wr = 1'b1; b_Addr = 16'h0020; b_WData = 16'h5555;
        next_cycle();
        b_Req = 1'b0;
        n = -1; seen = 1'b0; wl = 0;
        for (int c = 1; c <= 8 && !seen; c++) begin
            @(negedge Clk);
            if (b_WE_N === 1'b0) wl++;
            if (b_Done === 1'b1) begin seen = 1'b1; n = c; end
            else next_cycle();
        end
        checks++;
        if (wl != 1 || n != 3) begin
            errors++;
            $display("FAIL w1_write: WE_N-low cycles %0d done cycle %0d required 1/3", wl, n);
        end
        next_cycle();
    endtask

    initial begin
        Reset = 1'b1; Req = 1'b0; Wr = 1'b0; Addr = 16'h0; WData = 16'h0;
        Switches = 16'h0; Data_from_SRAM = 16'h0;
        b_Req = 1'b0; b_Wr = 1'b0; b_Addr = 16'h0; b_WData = 16'h0;
        b_Switches = 16'h0; b_Data_from_SRAM = 16'h0;
        test_reset();
        test_read();
        test_write();
        test_io();
        test_req_busy();
        test_reset_mid_write();
        test_back_to_back();
        test_wait1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
